// File: rtl/sysarray_pkg.sv
// Shared types and helpers for the constant-adder stream arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sysarray_pkg;

    localparam int SYS_NUM_REQ     = 4;
    localparam int SYS_TDATA_WIDTH = 512;
    localparam int SYS_ADDER_WIDTH = 32;
    localparam int SYS_CNT_WIDTH   = 32;

    // Upper bound on requesters; the picker works on a vector this wide.
    localparam int SYS_MAX_REQ = 8;
    localparam int SYS_PTR_W   = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Round-robin pick: first set bit of valid_vec searching upward from
    // ptr+1 with wrap at num_req. The loop runs from the farthest offset to
    // the nearest so the nearest valid requester is assigned last and wins.
    // Returns ptr unchanged when nothing is valid.
    function automatic logic [SYS_PTR_W-1:0] rr_pick(
        input logic [SYS_MAX_REQ-1:0] valid_vec,
        input logic [SYS_PTR_W-1:0]   ptr,
        input int                     num_req
    );
        logic [SYS_PTR_W-1:0] win;
        logic [SYS_PTR_W-1:0] idx;
        win = ptr;
        for (int k = SYS_MAX_REQ; k >= 1; k--) begin
            if (k <= num_req) begin
                idx = SYS_PTR_W'((int'(ptr) + k) % num_req);
                if (valid_vec[idx]) begin
                    win = idx;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sysarray_axis_reg_slice.sv
// Single-entry registered AXIS slice carrying data/keep/last plus a sideband word.
// Latency: 1 cycle from input acceptance to out_vld.
// Backpressure: in_rdy = !out_vld || out_rdy; outputs frozen while stalled, load wins over drain.
module sysarray_axis_reg_slice
    import sysarray_pkg::*;
#(
    parameter int DATA_W = SYS_TDATA_WIDTH,
    parameter int KEEP_W = DATA_W / 8,
    parameter int SIDE_W = SYS_ADDER_WIDTH
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_dat,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_dat,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic [SIDE_W-1:0] out_side
);

    logic load;

    assign in_rdy = !out_vld || out_rdy;
    assign load   = in_vld && in_rdy;

    // Payload and sideband only move on a load, so the sideband stays beat-aligned.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
            out_side <= '0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_dat  <= in_dat;
            out_keep <= in_keep;
            out_last <= in_last;
            out_side <= in_side;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/sysarray_adder_arbiter.sv
// Round-robin packet-locked arbiter feeding one constant-adder stream; constant rides with each beat.
// Latency: 1 idle arbitration cycle per packet, then 1 cycle from s-side acceptance to m_axis_tvalid.
// Backpressure: only the locked requester sees ready, equal to the output slice's ready; full rate when m_axis_tready stays high.
module sysarray_adder_arbiter
    import sysarray_pkg::*;
#(
    parameter int C_NUM_REQ          = SYS_NUM_REQ,
    parameter int C_AXIS_TDATA_WIDTH = SYS_TDATA_WIDTH,
    parameter int C_ADDER_BIT_WIDTH  = SYS_ADDER_WIDTH,
    parameter int C_CNT_WIDTH        = SYS_CNT_WIDTH
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    input  logic                                    ctrl_enable,
    input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]  ctrl_constants,
    input  logic [C_NUM_REQ-1:0]                    s_axis_tvalid,
    output logic [C_NUM_REQ-1:0]                    s_axis_tready,
    input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_NUM_REQ-1:0]                    s_axis_tlast,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic                                    m_axis_tlast,
    output logic [C_ADDER_BIT_WIDTH-1:0]            m_constant,
    output logic [$clog2(C_NUM_REQ)-1:0]            grant_id,
    output logic                                    busy,
    output logic [C_CNT_WIDTH-1:0]                  beat_count,
    output logic [C_CNT_WIDTH-1:0]                  pkt_count
);

    localparam int GW = $clog2(C_NUM_REQ);
    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int KW = C_AXIS_TDATA_WIDTH / 8;
    localparam int AW = C_ADDER_BIT_WIDTH;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

    arb_state_t state, state_nxt;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] rr_ptr, rr_ptr_nxt;
    logic [SYS_MAX_REQ-1:0] req_vec;

    logic          sel_vld;
    logic          sel_rdy;
    logic [DW-1:0] sel_dat;
    logic [KW-1:0] sel_keep;
    logic          sel_last;
    logic [AW-1:0] sel_const;
    logic          sel_accept;

    // Mux the locked requester's beat and its constant toward the output slice.
    always_comb begin
        sel_dat   = s_axis_tdata[int'(grant_id)*DW +: DW];
        sel_keep  = s_axis_tkeep[int'(grant_id)*KW +: KW];
        sel_last  = s_axis_tlast[grant_id];
        sel_const = ctrl_constants[int'(grant_id)*AW +: AW];
        sel_vld   = (state == ST_LOCKED) && s_axis_tvalid[grant_id];
    end

    assign sel_accept = sel_vld && sel_rdy;

    // Widen the request vector to the picker's fixed width.
    always_comb begin
        req_vec = '0;
        req_vec[C_NUM_REQ-1:0] = s_axis_tvalid;
    end

    // FSM state, grant and round-robin pointer registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            rr_ptr   <= GW'(C_NUM_REQ - 1);
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    // Next-state: grant in IDLE (never in the cycle a packet ends), release on accepted tlast.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_id;
        rr_ptr_nxt    = rr_ptr;
        s_axis_tready = '0;
        case (state)
            ST_IDLE: begin
                if (ctrl_enable && (|s_axis_tvalid)) begin
                    grant_nxt = GW'(rr_pick(req_vec, SYS_PTR_W'(rr_ptr), C_NUM_REQ));
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                s_axis_tready[grant_id] = sel_rdy;
                if (sel_accept && sel_last) begin
                    rr_ptr_nxt = grant_id;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    sysarray_axis_reg_slice #(
        .DATA_W (DW),
        .KEEP_W (KW),
        .SIDE_W (AW)
    ) u_out_slice (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_vld   (sel_vld),
        .in_rdy   (sel_rdy),
        .in_dat   (sel_dat),
        .in_keep  (sel_keep),
        .in_last  (sel_last),
        .in_side  (sel_const),
        .out_vld  (m_axis_tvalid),
        .out_rdy  (m_axis_tready),
        .out_dat  (m_axis_tdata),
        .out_keep (m_axis_tkeep),
        .out_last (m_axis_tlast),
        .out_side (m_constant)
    );

    // Beat and packet counters on m-side handshakes; free-running wrap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            beat_count <= beat_count + CNT_ONE;
            if (m_axis_tlast) begin
                pkt_count <= pkt_count + CNT_ONE;
            end
        end
    end

    assign busy = (state == ST_LOCKED) || m_axis_tvalid;

endmodule

// File: tb/tb_sysarray_adder_arbiter.sv
module tb_sysarray_adder_arbiter;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int AW = 32;
    localparam int CW = 32;
    localparam int GW = 2;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic               ctrl_enable;
    logic [NR*AW-1:0]   ctrl_constants;
    logic [NR-1:0]      s_axis_tvalid;
    logic [NR-1:0]      s_axis_tready;
    logic [NR*DW-1:0]   s_axis_tdata;
    logic [NR*KW-1:0]   s_axis_tkeep;
    logic [NR-1:0]      s_axis_tlast;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [DW-1:0]      m_axis_tdata;
    logic [KW-1:0]      m_axis_tkeep;
    logic               m_axis_tlast;
    logic [AW-1:0]      m_constant;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic [CW-1:0]      beat_count;
    logic [CW-1:0]      pkt_count;

    sysarray_adder_arbiter #(
        .C_NUM_REQ          (NR),
        .C_AXIS_TDATA_WIDTH (DW),
        .C_ADDER_BIT_WIDTH  (AW),
        .C_CNT_WIDTH        (CW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .ctrl_enable    (ctrl_enable),
        .ctrl_constants (ctrl_constants),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_constant     (m_constant),
        .grant_id       (grant_id),
        .busy           (busy),
        .beat_count     (beat_count),
        .pkt_count      (pkt_count)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester source model and m-side log.
    int             src_left [NR];
    int             src_beat [NR];
    int             src_pkt  [NR];
    int             src_len  [NR];
    int             src_more [NR];
    logic [NR-1:0]  hs;
    logic [AW-1:0]  cst_of   [NR];
    int             cyc;
    int             tr_q     [$];

    logic [DW-1:0]  ob_dat  [$];
    logic [AW-1:0]  ob_cst  [$];
    logic [KW-1:0]  ob_keep [$];
    logic           ob_last [$];
    int             ob_cyc  [$];

    logic           stalled;
    logic [DW-1:0]  st_dat;
    logic [AW-1:0]  st_cst;
    int             n_stall;

    function automatic logic [DW-1:0] mk_dat(input int r, input int p, input int b);
        return {8'hA5, 8'(r), 16'(p), 16'(b), 16'h5A5A};
    endfunction

    function automatic logic [KW-1:0] mk_keep(input int r);
        return 8'hF0 | 8'(r + 1);
    endfunction

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            s_axis_tvalid[r]            = (src_left[r] != 0);
            s_axis_tlast[r]             = (src_left[r] == 1);
            s_axis_tdata[r*DW +: DW]    = mk_dat(r, src_pkt[r], src_beat[r]);
            s_axis_tkeep[r*KW +: KW]    = mk_keep(r);
        end
        if (tr_q.size() > 0) m_axis_tready = tr_q.pop_front() != 0;
        else                 m_axis_tready = 1'b1;
    endtask

    task automatic start_pkt(input int r, input int len, input int more);
        src_len[r]  = len;
        src_left[r] = len;
        src_beat[r] = 0;
        src_pkt[r]  = 0;
        src_more[r] = more;
    endtask

    task automatic clear_src();
        for (int r = 0; r < NR; r++) begin
            src_left[r] = 0; src_beat[r] = 0; src_pkt[r] = 0;
            src_len[r]  = 0; src_more[r] = 0;
        end
        hs = '0;
        stalled = 1'b0;
        tr_q.delete();
    endtask

    task automatic clear_log();
        ob_dat.delete(); ob_cst.delete(); ob_keep.delete();
        ob_last.delete(); ob_cyc.delete();
    endtask

    // One clock: sample at negedge, advance sources and drive after posedge.
    task automatic step();
        @(negedge aclk);
        if (aresetn) begin
            if (stalled) begin
                chk("stall_vld", m_axis_tvalid, 1'b1);
                chk("stall_dat", m_axis_tdata, st_dat);
                chk("stall_cst", m_constant, st_cst);
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            if (stalled) begin
                n_stall++;
                st_dat = m_axis_tdata;
                st_cst = m_constant;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                ob_dat.push_back(m_axis_tdata);
                ob_cst.push_back(m_constant);
                ob_keep.push_back(m_axis_tkeep);
                ob_last.push_back(m_axis_tlast);
                ob_cyc.push_back(cyc);
            end
            hs = s_axis_tvalid & s_axis_tready;
        end
        @(posedge aclk);
        cyc++;
        #1;
        for (int r = 0; r < NR; r++) begin
            if (hs[r]) begin
                src_beat[r]++;
                src_left[r]--;
                if (src_left[r] == 0 && src_more[r] > 0) begin
                    src_more[r]--;
                    src_pkt[r]++;
                    src_beat[r] = 0;
                    src_left[r] = src_len[r];
                end
            end
        end
        drive();
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (ob_dat.size() < n && b < budget) begin
            step();
            b++;
        end
        chk(tag, ob_dat.size(), n);
    endtask

    task automatic exp_beat(input string tag, input int i, input int r, input int p,
                            input int b, input logic last);
        if (i < ob_dat.size()) begin
            chk({tag, "_dat"},  ob_dat[i],  mk_dat(r, p, b));
            chk({tag, "_cst"},  ob_cst[i],  cst_of[r]);
            chk({tag, "_keep"}, ob_keep[i], mk_keep(r));
            chk({tag, "_last"}, ob_last[i], last);
        end else begin
            chk({tag, "_missing"}, ob_dat.size(), i + 1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mvld"},   m_axis_tvalid, 1'b0);
        chk({tag, "_srdy"},   s_axis_tready, 4'h0);
        chk({tag, "_grant"},  grant_id, 2'd0);
        chk({tag, "_busy"},   busy, 1'b0);
        chk({tag, "_beats"},  beat_count, 0);
        chk({tag, "_pkts"},   pkt_count, 0);
        chk({tag, "_mdat"},   m_axis_tdata, 0);
        chk({tag, "_mkeep"},  m_axis_tkeep, 0);
        chk({tag, "_mlast"},  m_axis_tlast, 1'b0);
        chk({tag, "_mcst"},   m_constant, 0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_src();
        drive();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int c0;
        int base;
        cst_of[0] = 32'd100;
        cst_of[1] = 32'd5;
        cst_of[2] = 32'd200;
        cst_of[3] = 32'd300;
        for (int r = 0; r < NR; r++) ctrl_constants[r*AW +: AW] = cst_of[r];
        ctrl_enable = 1'b1;
        n_stall = 0;
        st_dat = '0;
        st_cst = '0;
        cyc = 0;
        aresetn = 1'b0;
        clear_src();
        drive();
        repeat (2) @(posedge aclk);
        #1;
        chk_reset_vals("rst_hold");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk_reset_vals("rst_rel");

        // Single requester, 4 beats from req1.
        clear_log();
        c0 = cyc;
        start_pkt(1, 4, 0);
        drive();
        wait_beats("t1_beats", 4, 30);
        for (int b = 0; b < 4; b++) exp_beat("t1", b, 1, 0, b, b == 3);
        if (ob_cyc.size() > 0) chk("t1_latency", ob_cyc[0] - c0, 2);
        repeat (3) step();
        chk("t1_grant", grant_id, 2'd1);
        chk("t1_beat_count", beat_count, 4);
        chk("t1_pkt_count", pkt_count, 1);
        chk("t1_busy_idle", busy, 1'b0);

        // Round robin: all four continuously valid, 2-beat packets, two packets each.
        do_reset();
        clear_log();
        for (int r = 0; r < NR; r++) start_pkt(r, 2, 1);
        drive();
        wait_beats("t2_beats", 16, 120);
        for (int k = 0; k < 8; k++) begin
            exp_beat("t2_b0", 2*k,     k % 4, k / 4, 0, 1'b0);
            exp_beat("t2_b1", 2*k + 1, k % 4, k / 4, 1, 1'b1);
        end
        for (int i = 1; i < ob_cyc.size(); i++) begin
            chk("t2_gap", ob_cyc[i] - ob_cyc[i-1], (i % 2 == 1) ? 1 : 2);
        end
        repeat (3) step();
        chk("t2_beat_count", beat_count, 16);
        chk("t2_pkt_count", pkt_count, 8);

        // Backpressure: m_axis_tready 1,0,0,1 across a 3-beat packet.
        clear_log();
        n_stall = 0;
        base = int'(beat_count);
        tr_q = '{1, 1, 1, 0, 0, 1};
        start_pkt(0, 3, 0);
        drive();
        wait_beats("t3_beats", 3, 30);
        for (int b = 0; b < 3; b++) exp_beat("t3", b, 0, 0, b, b == 2);
        repeat (3) step();
        chk("t3_stalls", n_stall, 2);
        chk("t3_no_dup", ob_dat.size(), 3);
        chk("t3_beat_delta", int'(beat_count) - base, 3);

        // Enable dropped at beat 2 of a 5-beat req2 packet.
        clear_log();
        start_pkt(2, 5, 0);
        drive();
        wait_beats("t4_first", 1, 20);
        ctrl_enable = 1'b0;
        start_pkt(3, 2, 0);
        start_pkt(0, 2, 0);
        drive();
        wait_beats("t4_beats", 5, 30);
        for (int b = 0; b < 5; b++) exp_beat("t4", b, 2, 0, b, b == 4);
        repeat (6) step();
        chk("t4_no_grant", ob_dat.size(), 5);
        chk("t4_busy", busy, 1'b0);
        chk("t4_srdy", s_axis_tready, 4'h0);
        ctrl_enable = 1'b1;
        wait_beats("t4_resume", 9, 30);
        exp_beat("t4_r3a", 5, 3, 0, 0, 1'b0);
        exp_beat("t4_r3b", 6, 3, 0, 1, 1'b1);
        exp_beat("t4_r0a", 7, 0, 0, 0, 1'b0);
        exp_beat("t4_r0b", 8, 0, 0, 1, 1'b1);

        // Async reset at beat 3 of a 6-beat req1 packet.
        repeat (2) step();
        clear_log();
        start_pkt(1, 6, 0);
        drive();
        wait_beats("t5_pre", 3, 30);
        aresetn = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        clear_src();
        drive();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clear_log();
        start_pkt(2, 1, 0);
        start_pkt(0, 1, 0);
        drive();
        wait_beats("t5_beats", 2, 30);
        exp_beat("t5_first", 0, 0, 0, 0, 1'b1);
        exp_beat("t5_second", 1, 2, 0, 0, 1'b1);
        repeat (2) step();
        chk("t5_beat_count", beat_count, 2);
        chk("t5_pkt_count", pkt_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a wait loop is ever broken.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sysarray_adder_arbiter.md
Name: sysarray_adder_arbiter

Overview:
- Round-robin, packet-locked AXI4-Stream arbiter that shares one pipelined constant-adder datapath among C_NUM_REQ requester streams.
- Each requester has its own add constant. The arbiter drives the adder's constant input beat-aligned with the data, so packets from different requesters use different constants.
- Sits between the kernel's read-side stream sources and the adder's slave AXIS port.

Parameters:
- C_NUM_REQ, 4, number of requester streams (2..8).
- C_AXIS_TDATA_WIDTH, 512, tdata width of all streams.
- C_ADDER_BIT_WIDTH, 32, width of each per-requester constant.
- C_CNT_WIDTH, 32, width of the beat and packet status counters.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- ctrl_enable  in  1  when low, no new grants are issued; a packet in progress completes.
- ctrl_constants  in  C_NUM_REQ*C_ADDER_BIT_WIDTH  requester r's constant is at [r*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH].
- s_axis_tvalid  in  C_NUM_REQ  per-requester valid.
- s_axis_tready  out  C_NUM_REQ  per-requester ready.
- s_axis_tdata  in  C_NUM_REQ*C_AXIS_TDATA_WIDTH  flattened data.
- s_axis_tkeep  in  C_NUM_REQ*C_AXIS_TDATA_WIDTH/8  flattened keep.
- s_axis_tlast  in  C_NUM_REQ  per-requester last.
- m_axis_tvalid  out  1  to adder.
- m_axis_tready  in  1  from adder.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  to adder.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  to adder.
- m_axis_tlast  out  1  to adder.
- m_constant  out  C_ADDER_BIT_WIDTH  to adder ctrl_constant; valid whenever m_axis_tvalid is high.
- grant_id  out  $clog2(C_NUM_REQ)  requester currently locked.
- busy  out  1  high while state is LOCKED or the output register holds data.
- beat_count  out  C_CNT_WIDTH  total beats accepted on m_axis.
- pkt_count  out  C_CNT_WIDTH  total tlast beats accepted on m_axis.

Behaviour:
- Reset (async assert, sync release). All of the following are 0: m_axis_tvalid, s_axis_tready, grant_id, busy, counters, m_axis_tdata/tkeep/tlast, m_constant. State is IDLE. rr_ptr = C_NUM_REQ-1, so requester 0 has first priority.
- Reset mid-packet: the partial packet is abandoned; the requester restarts from IDLE arbitration. No recovery of the partial packet is attempted.
- State IDLE:
  - If ctrl_enable is high and any s_axis_tvalid is high, register the winner as grant_id: first valid requester searching upward from rr_ptr+1 with wrap-around.
  - Go to LOCKED next cycle. All s_axis_tready stay 0 in IDLE, giving a 1-cycle arbitration bubble per packet.
- State LOCKED:
  - s_axis_tready[grant_id] = out_ready; all other readies are 0.
  - out_ready = !m_axis_tvalid || m_axis_tready.
  - On an accepted input beat with tlast=1: rr_ptr <= grant_id, go to IDLE.
  - ctrl_enable falling has no effect until tlast.
- Output stage: single registered slice, latency 1 cycle from s-side acceptance to m_axis_tvalid.
  - On acceptance, load tdata/tkeep/tlast from requester grant_id, and load m_constant from ctrl_constants[grant_id] sampled the same cycle.
  - Hold all outputs stable while m_axis_tvalid && !m_axis_tready.
  - Clear tvalid on m-side acceptance if no new beat loads.
  - Full throughput (1 beat/cycle) in LOCKED while m_axis_tready is held high.
- Constant alignment: m_constant changes only together with a new beat load, so the adder's registered constant stays beat-aligned.
- Counters:
  - beat_count += 1 on every m_axis_tvalid && m_axis_tready; pkt_count += 1 when that beat also has tlast.
  - Both wrap modulo 2^C_CNT_WIDTH with no saturation.
- Simultaneous events:
  - Last beat accepted and a new requester valid in the same cycle: no same-cycle regrant; the next grant is decided in the following IDLE cycle.
  - Output register drain and load in the same cycle: load wins and tvalid stays 1.
- tvalid dropped by the locked requester mid-packet: arbiter stays LOCKED and waits; no timeout.
- Zero-length packets do not exist; every packet has at least one beat.

Decomposition:
- Shared package sysarray_pkg holds:
  - FSM state enum (ST_IDLE, ST_LOCKED);
  - function rr_pick(valid_vec, ptr) returning the winner index;
  - default widths as localparams.
- One natural sub-module: sysarray_axis_reg_slice. It is the registered output stage, carrying tdata/tkeep/tlast plus C_ADDER_BIT_WIDTH of sideband for the constant. The arbiter FSM and counters stay in the top.

Test Plan:
- Single requester: req1 sends a 4-beat packet, ctrl_constants[1]=5, m_axis_tready=1 -> grant_id=1; 4 m-beats with m_constant=5, tlast on beat 4; pkt_count=1, beat_count=4; first m_axis_tvalid 2 cycles after req1 tvalid.
- Round-robin fairness: all 4 requesters continuously valid, 2-beat packets each -> grant order 0,1,2,3,0; each packet carries its own constant; one idle cycle between packets.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 3-beat packet -> no beat lost or duplicated; tdata/m_constant stable while stalled; beat_count=3 at end.
- ctrl_enable dropped at beat 2 of a 5-beat packet from req2 -> all 5 beats complete; no further grant while disabled; re-enable -> next requester after 2 granted.
- Async reset: aresetn asserted mid-packet (beat 3 of 6) -> all outputs 0 immediately; after release, req0 granted first and counters restart at 0.
